key_provisioner: RTL and testbench
==================================

Name: key_provisioner

Overview:
- Serial key-delivery block feeding the 8-bit key port of our locked benchmark netlists: 4 mux-select key bits (p1..p4) and 4 XOR key bits (X_1..X_4).
- Accepts a framed serial key stream from the secure-storage/scan side and parity-checks it.
- Presents the decoded key to the locked circuit only once the frame has been validated.
- Drives a decoy key until a valid frame arrives, and locks out after repeated bad frames, throttling brute-force key search.

Parameters:
- KEY_W, 8, key width in bits; bits [3:0] drive the mux key, bits [7:4] drive the XOR key.
- DECOY_KEY, 8'h00, key value driven whenever no validated key is held.
- MAX_FAIL, 3, number of consecutive parity failures that triggers lockout (>=1).
- CNT_W, 2, width of fail_cnt; must hold MAX_FAIL.

Ports:
- clk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- ser_valid  in  1  serial beat valid.
- ser_data  in  1  serial beat data.
- ser_ready  out  1  block accepts a beat this cycle.
- clear  in  1  drop the held key and return to IDLE.
- key_p  out  4  mux key bits to the locked netlist (p1=bit0 .. p4=bit3).
- key_x  out  4  XOR key bits to the locked netlist (X_1=bit0 .. X_4=bit3).
- key_valid  out  1  high while a validated key is driven.
- load_err  out  1  one-cycle pulse on a parity failure.
- locked_out  out  1  sticky lockout flag.
- fail_cnt  out  CNT_W  count of consecutive failures.

Behaviour:
- Reset is synchronous and active-high on clk, and has priority over every other input.
- Reset values: state=IDLE; {key_x,key_p}=DECOY_KEY; key_valid=0; load_err=0; locked_out=0; fail_cnt=0; ser_ready=1.
- A beat is accepted when ser_valid & ser_ready. Gaps in ser_valid are allowed anywhere within a frame.
- Frame format: KEY_W data beats, LSB first (K[0] first), followed by 1 parity beat. Parity is even: XOR over data and parity bits = 0.
- States: IDLE, SHIFT, CHECK, ARMED, LOCKOUT.
- IDLE:
  - ser_ready=1.
  - The first accepted beat is K[0]; the shift register loads it, bit count=1, next state=SHIFT.
- SHIFT:
  - ser_ready=1.
  - Accept the remaining data beats, then the parity beat.
  - On the cycle the parity beat is accepted, next state=CHECK.
- CHECK:
  - One cycle; ser_ready=0.
  - Parity OK -> latch K into {key_x,key_p}, key_valid=1 from the next cycle, fail_cnt=0, next state=ARMED.
  - Parity bad -> load_err=1 for the next cycle only, fail_cnt+1. If the new count equals MAX_FAIL, next state=LOCKOUT; otherwise next state=IDLE.
- Latency: parity beat accepted in cycle t -> CHECK in t+1 -> key outputs and key_valid (or load_err) updated in t+2.
- ARMED:
  - ser_ready=0; beats are ignored.
  - The key is held stable; the outputs never change mid-frame.
  - clear=1 -> next cycle key=DECOY_KEY, key_valid=0, state=IDLE; fail_cnt is unchanged.
- LOCKOUT:
  - ser_ready=0, locked_out=1, key=DECOY_KEY, key_valid=0.
  - clear is ignored; only rst exits this state.
- clear in SHIFT: abort the frame, discard the partial shift data, go to IDLE. This is not counted as a failure and produces no load_err.
- clear in IDLE or CHECK: ignored, and CHECK completes normally. Simultaneous clear and an accepted beat in SHIFT: clear wins and the beat is dropped.
- Decoy rule: key outputs equal DECOY_KEY in every state except ARMED. The partial shift register is never visible on key_p/key_x.
- Saturation: fail_cnt never exceeds MAX_FAIL.

Decomposition:
- Shared package key_prov_pkg holds:
  - the state enum (IDLE, SHIFT, CHECK, ARMED, LOCKOUT);
  - the KEY_W default and the field slices for the mux-key and XOR-key halves;
  - the even-parity function.
- One sub-module, key_shift_rx, is natural: the serial shift register, bit counter and running parity. It reports frame_done and parity_ok to the FSM. The FSM and key hold register stay in key_provisioner.

Test Plan:
- Key 0xA5, parity beat 0, no gaps -> 2 cycles after the parity beat: key_p=4'h5, key_x=4'hA, key_valid=1, fail_cnt=0.
- Key 0xA5 with parity beat 1 -> load_err pulses for 1 cycle, fail_cnt=1, key_valid=0, key outputs stay 8'h00, state IDLE.
- Three consecutive bad frames -> after the third, locked_out=1, ser_ready=0. A subsequent good 0x3C frame and clear are both ignored; rst returns fail_cnt=0 and locked_out=0.
- Key 0x3C sent with random 0-3 cycle ser_valid gaps -> key_p=4'hC, key_x=4'h3. Outputs stay 8'h00 until t+2 after the parity beat.
- ARMED with 0xA5, assert clear -> next cycle key=8'h00, key_valid=0, state IDLE. Then reload 0x0F (parity 0) -> key_p=4'hF, key_x=4'h0.
- rst asserted after 5 data beats of a frame (and separately, clear asserted mid-frame) -> IDLE, no load_err, fail_cnt unchanged by clear. The next complete 0xA5 frame arms correctly.

Source files
------------

// File: rtl/key_prov_pkg.sv
// rtl/key_prov_pkg.sv - shared types, key field slices and parity helper for key_provisioner
package key_prov_pkg;

  localparam int KEY_W_DEF = 8;

  // Mux-key half drives p1..p4, XOR-key half drives X_1..X_4
  localparam int KEY_P_LSB = 0;
  localparam int KEY_P_MSB = 3;
  localparam int KEY_X_LSB = 4;
  localparam int KEY_X_MSB = 7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_CHECK,
    ST_ARMED,
    ST_LOCKOUT
  } state_t;

  // Running even parity: restarts on the first beat of a frame
  function automatic logic even_parity_acc(input logic acc, input logic bit_in,
                                           input logic first);
    return first ? bit_in : (acc ^ bit_in);
  endfunction

endpackage

// File: rtl/key_provisioner_if.sv
// rtl/key_provisioner_if.sv - serial key stream and key-port bundle for key_provisioner
interface key_provisioner_if #(
  parameter int CNT_W = 2
);
  logic             ser_valid;
  logic             ser_data;
  logic             ser_ready;
  logic             clear;
  logic [3:0]       key_p;
  logic [3:0]       key_x;
  logic             key_valid;
  logic             load_err;
  logic             locked_out;
  logic [CNT_W-1:0] fail_cnt;

  modport master (
    output ser_valid, ser_data, clear,
    input  ser_ready, key_p, key_x, key_valid, load_err, locked_out, fail_cnt
  );

  modport slave (
    input  ser_valid, ser_data, clear,
    output ser_ready, key_p, key_x, key_valid, load_err, locked_out, fail_cnt
  );
endinterface

// File: rtl/key_shift_rx.sv
// rtl/key_shift_rx.sv - serial key deserializer with beat counter and running parity
module key_shift_rx
  import key_prov_pkg::*;
#(
  parameter int KEY_W = KEY_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_beat,
  input  logic             i_data,
  input  logic             i_flush,
  output logic             o_frame_done,
  output logic             o_parity_ok,
  output logic [KEY_W-1:0] o_key
);
  localparam int CW = $clog2(KEY_W + 1);
  localparam logic [CW-1:0] LAST_BEAT = CW'(KEY_W);

  logic [CW-1:0]    r_cnt;
  logic [KEY_W-1:0] r_shift;
  logic             r_par;

  assign o_frame_done = i_beat && (r_cnt == LAST_BEAT);
  assign o_parity_ok  = (r_par == 1'b0);
  assign o_key        = r_shift;

  // Parity result stays valid after the last beat until the next frame starts
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_cnt   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
    end else if (i_beat) begin
      r_par <= even_parity_acc(r_par, i_data, r_cnt == '0);
      if (r_cnt == LAST_BEAT) begin
        r_cnt <= '0;
      end else begin
        r_cnt   <= r_cnt + CW'(1);
        r_shift <= {i_data, r_shift[KEY_W-1:1]};
      end
    end
  end

endmodule

// File: rtl/key_provisioner.sv
// rtl/key_provisioner.sv - validated serial key delivery with decoy key and failure lockout
module key_provisioner
  import key_prov_pkg::*;
#(
  parameter int               KEY_W     = KEY_W_DEF,
  parameter logic [KEY_W-1:0] DECOY_KEY = '0,
  parameter int               MAX_FAIL  = 3,
  parameter int               CNT_W     = 2
) (
  input logic              clk,
  input logic              rst,
  key_provisioner_if.slave bus
);
  localparam logic [CNT_W-1:0] MAX_FAIL_C = CNT_W'(MAX_FAIL);

  state_t           r_state;
  logic [KEY_W-1:0] r_key;
  logic             r_key_valid;
  logic             r_load_err;
  logic             r_locked_out;
  logic             r_ser_ready;
  logic [CNT_W-1:0] r_fail_cnt;

  logic             w_abort;
  logic             w_beat;
  logic             w_frame_done;
  logic             w_parity_ok;
  logic [KEY_W-1:0] w_rx_key;
  logic [CNT_W-1:0] w_fail_next;

  // clear in SHIFT beats a simultaneous data beat
  assign w_abort     = (r_state == ST_SHIFT) && bus.clear;
  assign w_beat      = bus.ser_valid && r_ser_ready && !w_abort;
  assign w_fail_next = (r_fail_cnt >= MAX_FAIL_C) ? MAX_FAIL_C : r_fail_cnt + CNT_W'(1);

  key_shift_rx #(
    .KEY_W(KEY_W)
  ) u_rx (
    .clk         (clk),
    .rst         (rst),
    .i_beat      (w_beat),
    .i_data      (bus.ser_data),
    .i_flush     (w_abort),
    .o_frame_done(w_frame_done),
    .o_parity_ok (w_parity_ok),
    .o_key       (w_rx_key)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_key        <= DECOY_KEY;
      r_key_valid  <= 1'b0;
      r_load_err   <= 1'b0;
      r_locked_out <= 1'b0;
      r_ser_ready  <= 1'b1;
      r_fail_cnt   <= '0;
    end else begin
      r_load_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_beat) r_state <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (w_abort) begin
            r_state <= ST_IDLE;
          end else if (w_frame_done) begin
            r_state     <= ST_CHECK;
            r_ser_ready <= 1'b0;
          end
        end
        ST_CHECK: begin
          if (w_parity_ok) begin
            r_key       <= w_rx_key;
            r_key_valid <= 1'b1;
            r_fail_cnt  <= '0;
            r_state     <= ST_ARMED;
          end else begin
            r_load_err <= 1'b1;
            r_fail_cnt <= w_fail_next;
            if (w_fail_next == MAX_FAIL_C) begin
              r_state      <= ST_LOCKOUT;
              r_locked_out <= 1'b1;
            end else begin
              r_state     <= ST_IDLE;
              r_ser_ready <= 1'b1;
            end
          end
        end
        ST_ARMED: begin
          if (bus.clear) begin
            r_key       <= DECOY_KEY;
            r_key_valid <= 1'b0;
            r_ser_ready <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        ST_LOCKOUT: begin
          r_key        <= DECOY_KEY;
          r_key_valid  <= 1'b0;
          r_ser_ready  <= 1'b0;
          r_locked_out <= 1'b1;
        end
        default: begin
          r_state     <= ST_IDLE;
          r_key       <= DECOY_KEY;
          r_key_valid <= 1'b0;
          r_ser_ready <= 1'b1;
        end
      endcase
    end
  end

  assign bus.ser_ready  = r_ser_ready;
  assign bus.key_p      = r_key[KEY_P_MSB:KEY_P_LSB];
  assign bus.key_x      = r_key[KEY_X_MSB:KEY_X_LSB];
  assign bus.key_valid  = r_key_valid;
  assign bus.load_err   = r_load_err;
  assign bus.locked_out = r_locked_out;
  assign bus.fail_cnt   = r_fail_cnt;

endmodule

// File: tb/tb_key_provisioner.sv
// tb/tb_key_provisioner.sv - scoreboard bench for key_provisioner
module tb_key_provisioner;

  typedef struct {
    logic       is_err;
    logic [3:0] kp;
    logic [3:0] kx;
    logic       kv;
    logic [1:0] fc;
    logic       lo;
    int         cyc;
  } exp_t;

  localparam int M_GOOD = 0;
  localparam int M_BAD  = 1;
  localparam int M_NONE = 2;

  logic clk;
  logic rst;
  int   cyc;
  int   tests;
  int   failed;
  int   exp_fail;
  exp_t q[$];

  key_provisioner_if #(.CNT_W(2)) bus_if ();

  key_provisioner dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  // Monitor: pops an expectation on every key_valid rise or load_err pulse
  initial begin
    logic prev_kv;
    exp_t e;
    prev_kv = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_kv = 1'b0;
      end else begin
        if (!bus_if.key_valid) check("decoy_key", {bus_if.key_x, bus_if.key_p}, 32'h0);
        if (bus_if.load_err || (bus_if.key_valid && !prev_kv)) begin
          if (q.size() == 0) begin
            check("unexpected_event", 1, 0);
          end else begin
            e = q.pop_front();
            check("ev_cycle", cyc, e.cyc);
            check("ev_load_err", bus_if.load_err, e.is_err);
            check("ev_key_p", bus_if.key_p, e.kp);
            check("ev_key_x", bus_if.key_x, e.kx);
            check("ev_key_valid", bus_if.key_valid, e.kv);
            check("ev_fail_cnt", bus_if.fail_cnt, e.fc);
            check("ev_locked_out", bus_if.locked_out, e.lo);
          end
        end
        prev_kv = bus_if.key_valid;
      end
    end
  end

  task automatic send_bit(input logic b, input int gap);
    bus_if.ser_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    bus_if.ser_valid = 1'b1;
    bus_if.ser_data  = b;
    @(posedge clk);
    #1;
    bus_if.ser_valid = 1'b0;
    bus_if.ser_data  = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] k, input logic par, input int maxgap, input int mode);
    exp_t e;
    for (int i = 0; i < 8; i++) send_bit(k[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
    send_bit(par, (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
    e.cyc = cyc + 1;
    if (mode == M_GOOD) begin
      exp_fail = 0;
      e.is_err = 1'b0; e.kp = k[3:0]; e.kx = k[7:4]; e.kv = 1'b1; e.fc = 2'd0; e.lo = 1'b0;
      q.push_back(e);
    end else if (mode == M_BAD) begin
      if (exp_fail < 3) exp_fail++;
      e.is_err = 1'b1; e.kp = 4'h0; e.kx = 4'h0; e.kv = 1'b0; e.fc = 2'(exp_fail);
      e.lo = (exp_fail == 3);
      q.push_back(e);
    end
  endtask

  task automatic pulse_clear();
    bus_if.clear = 1'b1;
    @(posedge clk);
    #1;
    bus_if.clear = 1'b0;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_fail = 0;
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
  endtask

  initial begin
    tests = 0; failed = 0; exp_fail = 0; cyc = 0;
    rst = 1'b1;
    bus_if.ser_valid = 1'b0; bus_if.ser_data = 1'b0; bus_if.clear = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_ser_ready", bus_if.ser_ready, 1);
    check("rst_key", {bus_if.key_x, bus_if.key_p}, 8'h00);
    check("rst_key_valid", bus_if.key_valid, 0);
    check("rst_load_err", bus_if.load_err, 0);
    check("rst_locked_out", bus_if.locked_out, 0);
    check("rst_fail_cnt", bus_if.fail_cnt, 0);

    // Good 0xA5, then beats in ARMED must be ignored
    send_frame(8'hA5, 1'b0, 0, M_GOOD);
    settle();
    check("armed_ser_ready", bus_if.ser_ready, 0);
    send_frame(8'h3C, 1'b0, 0, M_NONE);
    settle();
    check("armed_hold_key", {bus_if.key_x, bus_if.key_p}, 8'hA5);

    pulse_clear();
    @(negedge clk);
    check("clr_key", {bus_if.key_x, bus_if.key_p}, 8'h00);
    check("clr_key_valid", bus_if.key_valid, 0);
    check("clr_ser_ready", bus_if.ser_ready, 1);

    send_frame(8'h0F, 1'b0, 0, M_GOOD);
    settle();
    check("reload_key", {bus_if.key_x, bus_if.key_p}, 8'h0F);
    pulse_clear();

    // Bad parity: one-cycle load_err, back to IDLE
    send_frame(8'hA5, 1'b1, 0, M_BAD);
    settle();
    check("bad_load_err_off", bus_if.load_err, 0);
    check("bad_fail_cnt", bus_if.fail_cnt, 1);
    check("bad_ser_ready", bus_if.ser_ready, 1);

    // clear mid-frame: no failure counted
    for (int i = 0; i < 5; i++) send_bit(1'b1, 0);
    pulse_clear();
    settle();
    check("midclr_fail_cnt", bus_if.fail_cnt, 1);
    check("midclr_ser_ready", bus_if.ser_ready, 1);
    send_frame(8'hA5, 1'b0, 0, M_GOOD);
    settle();
    check("midclr_rearm", {bus_if.key_x, bus_if.key_p}, 8'hA5);
    pulse_clear();

    // rst mid-frame
    send_frame(8'hA5, 1'b1, 0, M_BAD);
    settle();
    for (int i = 0; i < 5; i++) send_bit(1'b0, 0);
    pulse_rst();
    @(negedge clk);
    check("midrst_fail_cnt", bus_if.fail_cnt, 0);
    check("midrst_ser_ready", bus_if.ser_ready, 1);
    send_frame(8'hA5, 1'b0, 0, M_GOOD);
    settle();
    check("midrst_rearm", bus_if.key_valid, 1);
    pulse_clear();

    // Gapped 0x3C
    send_frame(8'h3C, 1'b0, 3, M_GOOD);
    settle();
    check("gap_key", {bus_if.key_x, bus_if.key_p}, 8'h3C);
    pulse_clear();

    // Three bad frames -> lockout; good frame and clear ignored
    for (int n = 0; n < 3; n++) begin
      send_frame(8'hA5, 1'b1, 0, M_BAD);
      settle();
    end
    check("lo_locked_out", bus_if.locked_out, 1);
    check("lo_ser_ready", bus_if.ser_ready, 0);
    send_frame(8'h3C, 1'b0, 0, M_NONE);
    pulse_clear();
    settle();
    check("lo_sticky", bus_if.locked_out, 1);
    check("lo_key_valid", bus_if.key_valid, 0);
    check("lo_fail_cnt", bus_if.fail_cnt, 3);
    pulse_rst();
    @(negedge clk);
    check("unlock_fail_cnt", bus_if.fail_cnt, 0);
    check("unlock_locked_out", bus_if.locked_out, 0);
    check("unlock_ser_ready", bus_if.ser_ready, 1);

    settle();
    check("queue_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
